// File: rtl/cmd_framer.sv
// Byte-stream command framer: assembles {cmd,arg} frames, queues them and issues one per handshake pulse.
// Optional feature: define CMD_FRAMER_CHECKSUM_EN for 3-byte frames with an XOR checksum byte.
module cmd_framer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       jam,
  output logic       handshake,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       fifo_full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP);

  typedef enum logic [1:0] {S_CMD, S_ARG, S_CHK} state_t;

  state_t        r_state;
  logic [7:0]    r_cmd_l;
`ifdef CMD_FRAMER_CHECKSUM_EN
  logic [7:0]    r_arg_l;
`endif
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gap;
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [15:0]   r_mem [DEPTH];
  logic          r_handshake, r_fifo_full, r_overflow, r_frame_err;
  logic [7:0]    r_cmd, r_arg;

  logic          w_frame_done, w_chk_bad, w_timeout, w_empty, w_pop, w_push, w_full_nxt;
  logic [15:0]   w_frame;
  logic [AW:0]   w_wr_nxt, w_rd_nxt;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_frame_done = 1'b0;
    w_chk_bad    = 1'b0;
`ifdef CMD_FRAMER_CHECKSUM_EN
    w_frame = {r_cmd_l, r_arg_l};
    if (rx_valid && r_state == S_CHK) begin
      if (rx_data == (r_cmd_l ^ r_arg_l)) w_frame_done = 1'b1;
      else                                w_chk_bad    = 1'b1;
    end
`else
    w_frame = {r_cmd_l, rx_data};
    if (rx_valid && r_state == S_ARG) w_frame_done = 1'b1;
`endif
  end

  assign w_timeout  = (r_state != S_CMD) && !rx_valid && (r_tcnt == T_LAST);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_pop      = !w_empty && !jam && (r_gap == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
  assign w_push     = w_frame_done && (!r_fifo_full || w_pop);
  assign w_wr_nxt   = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt   = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_CMD;
      r_cmd_l <= '0;
`ifdef CMD_FRAMER_CHECKSUM_EN
      r_arg_l <= '0;
`endif
      r_tcnt  <= '0;
    end else if (rx_valid) begin
      r_tcnt <= '0;
      case (r_state)
        S_CMD: begin
          r_cmd_l <= rx_data;
          r_state <= S_ARG;
        end
`ifdef CMD_FRAMER_CHECKSUM_EN
        S_ARG: begin
          r_arg_l <= rx_data;
          r_state <= S_CHK;
        end
`endif
        default: r_state <= S_CMD;
      endcase
    end else if (r_state == S_CMD) begin
      r_tcnt <= '0;
    end else if (w_timeout) begin
      r_tcnt  <= '0;
      r_state <= S_CMD;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_full <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_handshake <= 1'b0;
      r_cmd       <= '0;
      r_arg       <= '0;
      r_gap       <= '0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_fifo_full <= w_full_nxt;
      r_frame_err <= w_timeout || w_chk_bad;
      r_handshake <= w_pop;
      if (w_frame_done && !w_push) r_overflow <= 1'b1;
      if (w_pop) begin
        {r_cmd, r_arg} <= r_mem[r_rd_ptr[AW-1:0]];
        r_gap          <= GAP_LD;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  // NOTE: storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_frame;
  end

  assign handshake = r_handshake;
  assign cmd       = r_cmd;
  assign arg       = r_arg;
  assign fifo_full = r_fifo_full;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_cmd_framer.sv
// Scoreboard bench for cmd_framer: stimulus queues expected frames, a negedge monitor checks each handshake.
// Also exercises the CMD_FRAMER_CHECKSUM_EN build when that macro is defined.
module tb_cmd_framer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       jam = 1'b0;
  logic       handshake, fifo_full, overflow, frame_err;
  logic [7:0] cmd, arg;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int fe_cnt   = 0;
  logic [15:0] exp_q[$];

  cmd_framer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(0)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .jam(jam),
    .handshake(handshake), .cmd(cmd), .arg(arg), .fifo_full(fifo_full),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and counts frame_err pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (handshake) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL hs_unexpected got %h%h required none", cmd, arg);
        end else begin
          check("hs_frame", {16'h0, cmd, arg}, {16'h0, exp_q.pop_front()});
        end
      end
      if (frame_err) fe_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input bit expect_issue);
    if (expect_issue) exp_q.push_back({c, a});
    send_byte(c);
    send_byte(a);
`ifdef CMD_FRAMER_CHECKSUM_EN
    send_byte(c ^ a);
`endif
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int hs0, fe0;
    #2;
    check("rst_handshake", {31'h0, handshake}, 0);
    check("rst_cmdarg", {16'h0, cmd, arg}, 0);
    check("rst_flags", {29'h0, fifo_full, overflow, frame_err}, 0);
    #20 rstn = 1'b1;
    idle(2);

    // 1: single frame, handshake one cycle after the final byte
    exp_q.push_back(16'h0288);
    send_byte(8'h02);
`ifdef CMD_FRAMER_CHECKSUM_EN
    send_byte(8'h88);
    send_byte(8'h8A);
`else
    send_byte(8'h88);
`endif
    check("t1_no_early_hs", {31'h0, handshake}, 0);
    idle(1);
    check("t1_hs_latency", {31'h0, handshake}, 1);
    check("t1_cmdarg", {16'h0, cmd, arg}, 32'h0288);
    idle(1);
    check("t1_hs_one_cycle", {31'h0, handshake}, 0);
    check("t1_cmdarg_hold", {16'h0, cmd, arg}, 32'h0288);
    wait_drain("t1_drain");

    // 2: back-to-back burst of three frames
    hs0 = hs_cnt;
    send_frame(8'h02, 8'h88, 1'b1);
    send_frame(8'h04, 8'h02, 1'b1);
    send_frame(8'h05, 8'h8A, 1'b1);
    wait_drain("t2_drain");
    check("t2_hs_count", hs_cnt - hs0, 3);

    // 3: jam holds the queue; fifth frame overflows
    hs0 = hs_cnt;
    jam = 1'b1;
    send_frame(8'h10, 8'h11, 1'b1);
    send_frame(8'h20, 8'h21, 1'b1);
    send_frame(8'h30, 8'h31, 1'b1);
    check("t3_not_full_at3", {31'h0, fifo_full}, 0);
    send_frame(8'h40, 8'h41, 1'b1);
    check("t3_full", {31'h0, fifo_full}, 1);
    check("t3_no_ovf_yet", {31'h0, overflow}, 0);
    send_frame(8'h50, 8'h51, 1'b0);
    idle(3);
    check("t3_overflow", {31'h0, overflow}, 1);
    check("t3_jam_no_hs", hs_cnt - hs0, 0);
    jam = 1'b0;
    wait_drain("t3_drain");
    check("t3_hs_count", hs_cnt - hs0, 4);
    check("t3_empty_not_full", {31'h0, fifo_full}, 0);
    check("t3_ovf_sticky", {31'h0, overflow}, 1);

    // 4: timeout discards a partial frame; expiry-cycle byte wins
    fe0 = fe_cnt;
    send_byte(8'h03);
    idle(TIMEOUT - 1);
    check("t4_no_err_early", {31'h0, frame_err}, 0);
    idle(1);
    check("t4_err_pulse", {31'h0, frame_err}, 1);
    idle(1);
    check("t4_err_one_cycle", {31'h0, frame_err}, 0);
    send_frame(8'h07, 8'h00, 1'b1);
    wait_drain("t4_drain");
    fe0 = fe_cnt;
    exp_q.push_back(16'h090A);
    send_byte(8'h09);
    idle(TIMEOUT - 1);
    send_byte(8'h0A);
`ifdef CMD_FRAMER_CHECKSUM_EN
    send_byte(8'h03);
`endif
    wait_drain("t4_expiry_drain");
    check("t4_expiry_no_err", fe_cnt - fe0, 0);

    // 5: reset mid-frame with frames queued
    jam = 1'b1;
    send_frame(8'h61, 8'h62, 1'b0);
    send_frame(8'h63, 8'h64, 1'b0);
    send_frame(8'h65, 8'h66, 1'b0);
    send_byte(8'h67);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_cmdarg", {16'h0, cmd, arg}, 0);
    check("t5_rst_flags", {28'h0, handshake, fifo_full, overflow, frame_err}, 0);
    idle(2);
    rstn = 1'b1;
    jam  = 1'b0;
    hs0  = hs_cnt;
    idle(10);
    check("t5_no_issue", hs_cnt - hs0, 0);
    send_frame(8'h0B, 8'h0C, 1'b1);
    wait_drain("t5_fresh_frame");

`ifdef CMD_FRAMER_CHECKSUM_EN
    // 6: checksum accept / reject
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    exp_q.push_back(16'h0244);
    send_byte(8'h02); send_byte(8'h44); send_byte(8'h46);
    wait_drain("t6_good_drain");
    send_byte(8'h02); send_byte(8'h44); send_byte(8'h00);
    idle(4);
    check("t6_hs_count", hs_cnt - hs0, 1);
    check("t6_bad_err", fe_cnt - fe0, 1);
    check("t6_no_ovf", {31'h0, overflow}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
